// File: rtl/exp_scheduler.sv
// Purpose: round-robin scheduler sharing one exponential engine between two requesters.
// Latency: gnt at cycle 0, eng_start at cycle 1, done accepted from cycle 3, res_valid one cycle after done.
// Backpressure: requests are level-held until granted; only one operation is outstanding at a time.
//
// Ports:
//   clk, rst (async, active-low)
//   req0/req1, x0/x1   : requester levels and operands
//   gnt0/gnt1          : one-cycle grant pulse (operand captured)
//   res_valid/res_id/res_int/res_frac/res_err : result pulse and held result fields
//   eng_start/eng_x    : command to the shared engine
//   eng_done/eng_int/eng_frac : engine completion and result
module exp_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        res_valid,
  output logic        res_id,
  output logic [1:0]  res_int,
  output logic [15:0] res_frac,
  output logic        res_err,
  output logic        eng_start,
  output logic [15:0] eng_x,
  input  logic        eng_done,
  input  logic [1:0]  eng_int,
  input  logic [15:0] eng_frac
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [15:0]   eng_x_q, eng_x_d;
  logic [1:0]    res_int_q, res_int_d;
  logic [15:0]   res_frac_q, res_frac_d;
  logic          res_err_q, res_err_d;
  logic          res_id_q, res_id_d;
  logic          gnt0_c, gnt1_c, eng_start_c, res_valid_c;
  logic          pick1;

  // With both requests up, serve the one not served last; otherwise serve whoever asks.
  assign pick1 = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    eng_x_d     = eng_x_q;
    res_int_d   = res_int_q;
    res_frac_d  = res_frac_q;
    res_err_d   = res_err_q;
    res_id_d    = res_id_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
    eng_start_c = 1'b0;
    res_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0_c  = ~pick1;
          gnt1_c  = pick1;
          eng_x_d = pick1 ? x1 : x0;
          owner_d = pick1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        eng_start_c = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // cnt_q == 0 marks the first WAIT cycle, where a leftover done is masked.
        if (cnt_q != '0 && eng_done) begin
          res_int_d  = eng_int;
          res_frac_d = eng_frac;
          res_err_d  = 1'b0;
          res_id_d   = owner_q;
          state_d    = DELIVER;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This increment brings the count to TIMEOUT: abort with an error result.
          res_int_d  = '0;
          res_frac_d = '0;
          res_err_d  = 1'b1;
          res_id_d   = owner_q;
          state_d    = DELIVER;
        end
        if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DELIVER: begin
        res_valid_c = 1'b1;
        last_d      = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      eng_x_q    <= '0;
      res_int_q  <= '0;
      res_frac_q <= '0;
      res_err_q  <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      eng_x_q    <= eng_x_d;
      res_int_q  <= res_int_d;
      res_frac_q <= res_frac_d;
      res_err_q  <= res_err_d;
      res_id_q   <= res_id_d;
    end
  end

  // Grants are decoded from the live request levels, so hold them low while in reset.
  assign gnt0      = gnt0_c & rst;
  assign gnt1      = gnt1_c & rst;
  assign eng_start = eng_start_c;
  assign res_valid = res_valid_c;
  assign eng_x     = eng_x_q;
  assign res_int   = res_int_q;
  assign res_frac  = res_frac_q;
  assign res_err   = res_err_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_exp_scheduler.sv
module tb_exp_scheduler;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] x0, x1;
  logic        gnt0, gnt1, res_valid, res_id, res_err, eng_start;
  logic [1:0]  res_int;
  logic [15:0] res_frac, eng_x;
  logic        eng_done;
  logic [1:0]  eng_int;
  logic [15:0] eng_frac;

  exp_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .x0(x0), .x1(x1),
    .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_id(res_id),
    .res_int(res_int), .res_frac(res_frac), .res_err(res_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done),
    .eng_int(eng_int), .eng_frac(eng_frac)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Cycle number advances just after each rising edge; negedge readers see the current cycle.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
  end

  // Engine model: done one cycle long, 10 cycles after eng_start, int=1, frac=operand.
  int          done_at = -100;
  int          eng_mode = 0;     // 0: normal, 1: never completes
  logic        force_done = 1'b0;
  logic [15:0] lat_x = '0;
  assign eng_done = ((cyc == done_at) && (eng_mode == 0)) || force_done;
  assign eng_int  = 2'd1;
  assign eng_frac = force_done ? 16'hDEAD : lat_x;

  // Observation logs for the literal checks.
  int   v_cyc[$], g_cyc[$], s_cyc[$];
  logic v_id[$], v_err[$], g_id[$];
  logic [1:0]  v_int[$];
  logic [15:0] v_frac[$];

  // Transaction-level model: an operation granted at cycle g starts at g+1, may accept
  // done in [g+3, g+1+TO], and otherwise aborts so the result appears at g+2+TO.
  bit          m_busy = 0, m_last = 1, m_own;
  int          m_g, m_dlv;
  logic [15:0] m_opx, m_ex = '0, m_frac = '0, p_frac;
  logic [1:0]  m_int = '0, p_int;
  logic        m_err = 0, m_id = 0, p_err;
  logic        e_g0, e_g1, e_st, e_v, pick;

  always @(negedge clk) begin
    e_g0 = 0; e_g1 = 0; e_st = 0; e_v = 0;
    if (!rst) begin
      m_busy = 0; m_last = 1; m_ex = '0;
      m_id = 0; m_int = '0; m_frac = '0; m_err = 0;
    end else if (!m_busy) begin
      if (req0 || req1) begin
        pick   = (req0 && req1) ? !m_last : req1;
        m_busy = 1; m_g = cyc; m_own = pick; m_dlv = -1;
        m_opx  = pick ? x1 : x0;
        e_g0   = !pick; e_g1 = pick;
      end
    end else begin
      if (cyc == m_g + 1) begin e_st = 1; m_ex = m_opx; end
      if (cyc == m_dlv) begin
        e_v = 1; m_id = m_own; m_int = p_int; m_frac = p_frac; m_err = p_err;
      end
    end
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("eng_start", eng_start, e_st);
    chk("res_valid", res_valid, e_v);
    chk("eng_x", eng_x, m_ex);
    chk("res_id", res_id, m_id);
    chk("res_int", res_int, m_int);
    chk("res_frac", res_frac, m_frac);
    chk("res_err", res_err, m_err);
    if (rst && m_busy && m_dlv < 0) begin
      if (eng_done && cyc >= m_g + 3 && cyc <= m_g + 1 + TO) begin
        m_dlv = cyc + 1; p_int = eng_int; p_frac = eng_frac; p_err = 0;
      end else if (cyc == m_g + 1 + TO) begin
        m_dlv = cyc + 1; p_int = '0; p_frac = '0; p_err = 1;
      end
    end
    if (rst && m_busy && cyc == m_dlv) begin m_busy = 0; m_last = m_own; end
    // logging and engine command capture
    if (res_valid) begin
      v_cyc.push_back(cyc); v_id.push_back(res_id); v_int.push_back(res_int);
      v_frac.push_back(res_frac); v_err.push_back(res_err);
    end
    if (gnt0 || gnt1) begin g_cyc.push_back(cyc); g_id.push_back(gnt1); end
    if (eng_start) begin s_cyc.push_back(cyc); done_at = cyc + 10; lat_x = eng_x; end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (gnt0 || gnt1) seen = 1;
    end
    chk("gnt_within_bound", seen, 1);
    step(1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("valid_within_bound", seen, 1);
    step(1);
  endtask

  task automatic chk_last(input string nm, input logic id, input logic [1:0] ri,
                          input logic [15:0] rf, input logic re, input int lat);
    chk({nm, "_id"},   v_id[$],   id);
    chk({nm, "_int"},  v_int[$],  ri);
    chk({nm, "_frac"}, v_frac[$], rf);
    chk({nm, "_err"},  v_err[$],  re);
    chk({nm, "_lat"},  v_cyc[$] - g_cyc[$], lat);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    step(n);
    rst = 1'b1;
  endtask

  int nv;

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0; x0 = '0; x1 = '0;
    step(3);
    chk("rst_eng_x", eng_x, 16'h0);
    chk("rst_res_frac", res_frac, 16'h0);
    rst = 1'b1;
    step(2);

    // Single request.
    req0 = 1; x0 = 16'h8000;
    wait_gnt(10);
    req0 = 0;
    wait_valid(40);
    chk_last("single", 1'b0, 2'd1, 16'h8000, 1'b0, 12);
    chk("single_start_lat", s_cyc[$] - g_cyc[$], 1);

    // Contention right after reset: req0 wins first.
    do_reset(2);
    req0 = 1; req1 = 1; x0 = 16'hE000; x1 = 16'hC000;
    wait_gnt(10);
    req0 = 0;
    chk("cont_first_gnt", g_id[$], 1'b0);
    wait_valid(40);
    chk_last("cont0", 1'b0, 2'd1, 16'hE000, 1'b0, 12);
    wait_gnt(10);
    req1 = 0;
    chk("cont_second_gnt", g_id[$], 1'b1);
    wait_valid(40);
    chk_last("cont1", 1'b1, 2'd1, 16'hC000, 1'b0, 12);

    // Fairness: both held across four operations.
    req0 = 1; req1 = 1; x0 = 16'h1111; x1 = 16'h2222;
    for (int k = 0; k < 4; k++) wait_gnt(30);
    req0 = 0; req1 = 0;
    wait_valid(40);
    chk("fair_g0", g_id[g_id.size()-4], 1'b0);
    chk("fair_g1", g_id[g_id.size()-3], 1'b1);
    chk("fair_g2", g_id[g_id.size()-2], 1'b0);
    chk("fair_g3", g_id[g_id.size()-1], 1'b1);
    chk("fair_gap", g_cyc[$] - g_cyc[g_cyc.size()-2], 13);
    chk("fair_last_frac", v_frac[$], 16'h2222);

    // Timeout: engine silent.
    eng_mode = 1;
    req0 = 1; x0 = 16'h1234;
    wait_gnt(10);
    req0 = 0;
    wait_valid(100);
    chk_last("tmo", 1'b0, 2'd0, 16'h0000, 1'b1, TO + 2);
    eng_mode = 0;
    req1 = 1; x1 = 16'h4321;
    wait_gnt(10);
    req1 = 0;
    wait_valid(40);
    chk_last("post_tmo", 1'b1, 2'd1, 16'h4321, 1'b0, 12);

    // Reset in the middle of WAIT; the late done must be ignored.
    req0 = 1; x0 = 16'h5555;
    wait_gnt(10);
    req0 = 0;
    step(5);
    nv = v_cyc.size();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_res_frac", res_frac, 16'h0);
    chk("midrst_eng_x", eng_x, 16'h0);
    step(2);
    rst = 1'b1;
    step(15);
    chk("midrst_no_valid", v_cyc.size(), nv);
    req0 = 1; x0 = 16'h6666;
    wait_gnt(10);
    req0 = 0;
    wait_valid(40);
    chk_last("post_rst", 1'b0, 2'd1, 16'h6666, 1'b0, 12);

    // Stale done held high through grant, LAUNCH and the first WAIT cycle.
    force_done = 1'b1;
    req1 = 1; x1 = 16'h7777;
    wait_gnt(10);
    req1 = 0;
    step(2);
    force_done = 1'b0;
    wait_valid(40);
    chk_last("stale", 1'b1, 2'd1, 16'h7777, 1'b0, 12);

    step(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
